timer_share_sched: RTL and testbench
====================================

# timer_share_sched

- Round-robin scheduler that shares one down-counting delay timer among `NREQ` requesters.
- Each requester raises a level request with its own delay value. The block grants one requester at a time, loads and runs the countdown, and pulses that requester's `done` when the count expires.
- It sits between the control FSMs that need timed waits and the single countdown resource, replacing per-FSM free-running down counters.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 24: countdown width in bits.

Ports:
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input NREQ: level request per requester.
- `delay` input NREQ*WIDTH: per-requester delay; requester i uses bits [i*WIDTH +: WIDTH].
- `grant` output NREQ: one-hot owner of the timer; all zero when idle.
- `done` output NREQ: one-cycle completion pulse to the owner.
- `busy` output 1: timer running (state RUN).
- `count` output WIDTH: current countdown value.

## Operation
- Reset value of every output is 0 (`grant`, `done`, `busy`, `count`). State resets to IDLE and the round-robin pointer `last` resets to NREQ-1, so requester 0 has first priority.
- States: IDLE, RUN.
- **IDLE:** if any eligible `req` bit is high, pick the winner by round-robin starting at index `last`+1 (mod NREQ). Then, on the next edge:
  - `grant` becomes the winner one-hot.
  - `count` loads the winner's `delay`.
  - `last` becomes the winner index.
  - `busy` goes to 1 and the state goes to RUN.
- **Eligible:** `req[i]` is high and `done[i]` is not asserted in that same cycle. This masks the just-finished requester for one cycle, so it can drop `req`.
- **RUN, count != 0:** `count` decrements by 1 per cycle.
- **RUN, count == 0:** on the next edge the state goes to IDLE, `done[owner]` goes to 1 for exactly one cycle, and `grant`, `busy` and `count` go to 0.
- **Arbitration in the done cycle:** arbitration runs in the IDLE cycle where `done` is high, among the other eligible requesters. Back-to-back service has no idle gap.
- **Delay capture:** `delay` is captured only at grant. Later changes to `delay` are ignored for the current run.
- **Arithmetic:** unsigned. The decrement never wraps, because RUN exits at 0.
- **Reset mid-run:** takes priority over everything. No `done` is issued, and outputs return to their reset values on the next edge.

## Timing
- `req[i]` high in IDLE at cycle t with delay D:
  - `grant[i]` and `busy` are high from t+1.
  - `count` is D at t+1, D-1 at t+2, and 0 at t+D+1.
  - `done[i]` is high at t+D+2 only.
- Total latency from request to `done` is D+2 cycles. D=0 gives `done` at t+2 after one RUN cycle.
- `grant` is registered and never changes owner during RUN.
- At most one `done` bit is high in any cycle.
- `done` and the next requester's grant: the next grant appears the cycle after `done` (at t+D+3) when another request was pending during the `done` cycle.

## Configuration
- **`TIMER_ABORT_EN` defined:** if the owner's `req` is low in any RUN cycle, the next edge returns to IDLE with `grant`, `busy` and `count` at 0 and no `done` pulse. The pointer `last` keeps the aborted index.
- **`TIMER_ABORT_EN` undefined:** `req` is ignored during RUN and the run always completes with `done`.

## Test plan
- Reset, then `req`=0001 with delay0=5 at cycle t -> `grant`=0001 at t+1, `count` 5,4,3,2,1,0, `done`=0001 at t+7 only, `busy` low at t+7.
- `req`=1111 held, all delays 2 -> grants in order 0,1,2,3,0. Each `done` is followed by the next grant one cycle later. No `done` overlaps.
- delay=0 on requester 2 only -> `done`=0100 two cycles after the request cycle.
- `delay` changed from 10 to 3 one cycle after grant -> the run still lasts 10 counts and `done` arrives at t+12.
- `rst` pulsed while `count`=4 in RUN -> all outputs 0 on the next edge and no `done`. A following request from requester 0 wins first.
- With `TIMER_ABORT_EN`, owner drops `req` when `count`=7 -> IDLE next cycle with no `done`. Without it, `done` still arrives on schedule.

Source files
------------

// File: rtl/timer_share_sched.sv
// timer_share_sched: round-robin scheduler that shares one down-counting delay
// timer among NREQ requesters. The winner's delay is captured at grant and
// counted down to zero; the owner then gets a one-cycle done pulse.
// Optional feature macro: TIMER_ABORT_EN. When it is defined, the owner
// dropping its request during a run aborts that run without a done pulse.
module timer_share_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   delay,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic [WIDTH-1:0]        count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IW-1:0]      last;
    logic [IW-1:0]      last_nxt;
    logic [IW-1:0]      win_idx;
    logic               win_found;
    logic [NREQ-1:0]    eligible;
    logic [NREQ-1:0]    grant_nxt;
    logic [NREQ-1:0]    done_nxt;
    logic               busy_nxt;
    logic [WIDTH-1:0]   count_nxt;
    logic               abort;
    logic               count_zero;

    assign count_zero = (count == {WIDTH{1'b0}});

`ifdef TIMER_ABORT_EN
    // Owner withdrew its request while the timer is running
    assign abort = (state == RUN) && ((req & grant) == {NREQ{1'b0}});
`else
    assign abort = 1'b0;
`endif

    // Round-robin pick among eligible requesters, searching from last+1;
    // the requester finishing this cycle is masked so it can drop req
    always_comb begin
        int cand;
        eligible  = req & ~done;
        win_found = 1'b0;
        win_idx   = {IW{1'b0}};
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last) + k) % NREQ;
            if (!win_found && eligible[IW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end else begin
                win_found = win_found;
            end
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= IW'(NREQ - 1);
            grant <= {NREQ{1'b0}};
            done  <= {NREQ{1'b0}};
            busy  <= 1'b0;
            count <= {WIDTH{1'b0}};
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            grant <= grant_nxt;
            done  <= done_nxt;
            busy  <= busy_nxt;
            count <= count_nxt;
        end
    end

    // Next-state decision: start on a winner, stop at zero or on abort
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (abort || count_zero) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and the round-robin pointer
    always_comb begin
        grant_nxt = grant;
        done_nxt  = {NREQ{1'b0}};
        busy_nxt  = busy;
        count_nxt = count;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    count_nxt = delay[int'(win_idx)*WIDTH +: WIDTH];
                    last_nxt  = win_idx;
                    busy_nxt  = 1'b1;
                end else begin
                    grant_nxt = {NREQ{1'b0}};
                    count_nxt = {WIDTH{1'b0}};
                    busy_nxt  = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    grant_nxt = {NREQ{1'b0}};
                    count_nxt = {WIDTH{1'b0}};
                    busy_nxt  = 1'b0;
                end else if (count_zero) begin
                    done_nxt  = grant;
                    grant_nxt = {NREQ{1'b0}};
                    count_nxt = {WIDTH{1'b0}};
                    busy_nxt  = 1'b0;
                end else begin
                    count_nxt = count - {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                grant_nxt = {NREQ{1'b0}};
                count_nxt = {WIDTH{1'b0}};
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_timer_share_sched.sv
// Self-checking bench for timer_share_sched (NREQ=4, WIDTH=24).
// Expected done events (requester, cycle) are queued when a request is driven
// and popped when the DUT pulses done.
module tb_timer_share_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 24;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] delay;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [WIDTH-1:0]      count;

    typedef struct {
        int idx;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_cmp;
    int   n_err;

    timer_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .delay (delay),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_delay(input int i, input int d);
        delay[i*WIDTH +: WIDTH] = WIDTH'(d);
    endtask

    // Tick until a done pulse is seen or the budget expires (idx = -1)
    task automatic wait_done(input int budget, output int idx, output int at);
        idx = -1;
        at  = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (done !== {NREQ{1'b0}}) begin
                for (int b = NREQ - 1; b >= 0; b--) begin
                    if (done[b] === 1'b1) idx = b;
                end
                at = cyc;
                return;
            end
        end
    endtask

    // Pop the next expected done event and compare with what was observed
    task automatic check_done(input string name, input int idx, input int at, input logic [NREQ-1:0] dv);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: unexpected done idx=%0d at cycle %0d", name, idx, at);
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if (idx !== e.idx || at !== e.cyc) begin
            n_err++;
            $display("FAIL %s: done idx=%0d cycle=%0d, required idx=%0d cycle=%0d", name, idx, at, e.idx, e.cyc);
        end
        n_cmp++;
        if (dv !== (4'b0001 << e.idx)) begin
            n_err++;
            $display("FAIL %s_onehot: done=%b, required=%b", name, dv, 4'b0001 << e.idx);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req   = 4'b0000;
        delay = '0;
        tick();
        tick();
        n_cmp++;
        if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || count !== 24'd0) begin
            n_err++;
            $display("FAIL reset: grant=%b done=%b busy=%b count=%0d, required all 0", grant, done, busy, count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int t, idx, at;
        set_delay(0, 5);
        req = 4'b0001;
        t = cyc;
        sb.push_back('{idx: 0, cyc: t + 7});
        tick();
        n_cmp++;
        if (grant !== 4'b0001 || busy !== 1'b1 || count !== 24'd5) begin
            n_err++;
            $display("FAIL single_grant: grant=%b busy=%b count=%0d, required 0001 1 5", grant, busy, count);
        end
        for (int c = 4; c >= 0; c--) begin
            tick();
            n_cmp++;
            if (count !== WIDTH'(c) || done !== 4'b0000) begin
                n_err++;
                $display("FAIL single_count: count=%0d done=%b, required %0d 0000", count, done, c);
            end
        end
        wait_done(10, idx, at);
        check_done("single_done", idx, at, done);
        req = 4'b0000;
        n_cmp++;
        if (busy !== 1'b0 || grant !== 4'b0000 || count !== 24'd0) begin
            n_err++;
            $display("FAIL single_idle: busy=%b grant=%b count=%0d, required 0 0000 0", busy, grant, count);
        end
        tick();
        n_cmp++;
        if (done !== 4'b0000 || grant !== 4'b0000) begin
            n_err++;
            $display("FAIL single_pulse: done=%b grant=%b, required 0000 0000", done, grant);
        end
    endtask

    task automatic test_back_to_back();
        int t, idx, at, nxt;
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_delay(i, 2);
        req = 4'b1111;
        t = cyc;
        for (int i = 0; i < 5; i++) sb.push_back('{idx: i % NREQ, cyc: t + 4 + 4 * i});
        for (int i = 0; i < 5; i++) begin
            wait_done(12, idx, at);
            check_done("rr_done", idx, at, done);
            if (i == 4) req = 4'b0000;
            nxt = (i + 1) % NREQ;
            tick();
            n_cmp++;
            if (i < 4 && grant !== (4'b0001 << nxt)) begin
                n_err++;
                $display("FAIL rr_grant: grant=%b, required %b", grant, 4'b0001 << nxt);
            end else if (i == 4 && grant !== 4'b0000) begin
                n_err++;
                $display("FAIL rr_stop: grant=%b, required 0000", grant);
            end
        end
        tick();
    endtask

    task automatic test_zero_delay();
        int t, idx, at;
        for (int i = 0; i < NREQ; i++) set_delay(i, 9);
        set_delay(2, 0);
        req = 4'b0100;
        t = cyc;
        sb.push_back('{idx: 2, cyc: t + 2});
        tick();
        n_cmp++;
        if (grant !== 4'b0100 || count !== 24'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL zero_grant: grant=%b count=%0d busy=%b, required 0100 0 1", grant, count, busy);
        end
        wait_done(5, idx, at);
        check_done("zero_done", idx, at, done);
        req = 4'b0000;
        tick();
    endtask

    task automatic test_delay_capture();
        int t, idx, at;
        set_delay(0, 10);
        req = 4'b0001;
        t = cyc;
        sb.push_back('{idx: 0, cyc: t + 12});
        tick();
        n_cmp++;
        if (grant !== 4'b0001 || count !== 24'd10) begin
            n_err++;
            $display("FAIL capture_load: grant=%b count=%0d, required 0001 10", grant, count);
        end
        set_delay(0, 3);
        tick();
        n_cmp++;
        if (count !== 24'd9) begin
            n_err++;
            $display("FAIL capture_count: count=%0d, required 9", count);
        end
        wait_done(20, idx, at);
        check_done("capture_done", idx, at, done);
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int t, idx, at, k;
        set_delay(0, 10);
        req = 4'b0001;
        tick();
        k = 0;
        while (count !== 24'd4 && k < 20) begin
            tick();
            k++;
        end
        n_cmp++;
        if (count !== 24'd4 || grant !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_reach: count=%0d grant=%b, required 4 0001", count, grant);
        end
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || count !== 24'd0) begin
            n_err++;
            $display("FAIL rst_mid: grant=%b done=%b busy=%b count=%0d, required all 0", grant, done, busy, count);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if (done !== 4'b0000) begin
                n_err++;
                $display("FAIL rst_nodone: done=%b, required 0000", done);
            end
        end
        set_delay(0, 1);
        set_delay(1, 1);
        req = 4'b0011;
        t = cyc;
        sb.push_back('{idx: 0, cyc: t + 3});
        tick();
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_prio: grant=%b, required 0001", grant);
        end
        wait_done(6, idx, at);
        check_done("rst_after_done", idx, at, done);
        req = 4'b0000;
        tick();
        n_cmp++;
        if (grant !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_after_idle: grant=%b, required 0000", grant);
        end
    endtask

    task automatic test_abort();
        int t, idx, at, k;
        set_delay(0, 10);
        req = 4'b0001;
        t = cyc;
        tick();
        k = 0;
        while (count !== 24'd7 && k < 20) begin
            tick();
            k++;
        end
        n_cmp++;
        if (count !== 24'd7 || cyc !== t + 4) begin
            n_err++;
            $display("FAIL abort_reach: count=%0d cycle=%0d, required 7 %0d", count, cyc, t + 4);
        end
        req = 4'b0000;
`ifdef TIMER_ABORT_EN
        tick();
        n_cmp++;
        if (grant !== 4'b0000 || busy !== 1'b0 || count !== 24'd0 || done !== 4'b0000) begin
            n_err++;
            $display("FAIL abort_idle: grant=%b busy=%b count=%0d done=%b, required all 0", grant, busy, count, done);
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            n_cmp++;
            if (done !== 4'b0000) begin
                n_err++;
                $display("FAIL abort_nodone: done=%b, required 0000", done);
            end
        end
`else
        sb.push_back('{idx: 0, cyc: t + 12});
        tick();
        n_cmp++;
        if (grant !== 4'b0001 || count !== 24'd6) begin
            n_err++;
            $display("FAIL noabort_run: grant=%b count=%0d, required 0001 6", grant, count);
        end
        wait_done(12, idx, at);
        check_done("noabort_done", idx, at, done);
`endif
        tick();
    endtask

    initial begin
        cyc   = 0;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        delay = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_delay();
        test_delay_capture();
        test_reset_mid_run();
        test_abort();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expected done events left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
